// File: rtl/acc_pkg.sv
// ============================================================================
// Module   : acc_pkg
// Purpose  : Shared opcode, ALU, state and select encodings for the
//            accumulator-processor instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_lda = 4'h1;
    localparam logic [3:0] c_op_sta = 4'h2;
    localparam logic [3:0] c_op_add = 4'h3;
    localparam logic [3:0] c_op_sub = 4'h4;
    localparam logic [3:0] c_op_and = 4'h5;
    localparam logic [3:0] c_op_or  = 4'h6;
    localparam logic [3:0] c_op_not = 4'h7;
    localparam logic [3:0] c_op_jmp = 4'h8;
    localparam logic [3:0] c_op_jz  = 4'h9;
    localparam logic [3:0] c_op_jc  = 4'hA;
    localparam logic [3:0] c_op_cla = 4'hB;
    localparam logic [3:0] c_op_hlt = 4'hF;

    localparam logic [2:0] c_alu_pass = 3'd0;
    localparam logic [2:0] c_alu_add  = 3'd1;
    localparam logic [2:0] c_alu_sub  = 3'd2;
    localparam logic [2:0] c_alu_and  = 3'd3;
    localparam logic [2:0] c_alu_or   = 3'd4;
    localparam logic [2:0] c_alu_not  = 3'd5;

    typedef logic [2:0] state_t;
    localparam state_t c_st_init   = 3'd0;
    localparam state_t c_st_fetch  = 3'd1;
    localparam state_t c_st_decode = 3'd2;
    localparam state_t c_st_exec   = 3'd3;
    localparam state_t c_st_halt   = 3'd4;

    localparam logic c_pc_sel_inc    = 1'b0;
    localparam logic c_pc_sel_opnd   = 1'b1;
    localparam logic c_addr_sel_pc   = 1'b0;
    localparam logic c_addr_sel_opnd = 1'b1;

    // ALU operation used by a memory-operand instruction during EXEC.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            c_op_add: return c_alu_add;
            c_op_sub: return c_alu_sub;
            c_op_and: return c_alu_and;
            c_op_or:  return c_alu_or;
            default:  return c_alu_pass;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_op_decode.sv
// ============================================================================
// Module   : acc_op_decode
// Purpose  : Combinational opcode classifier (memory / branch / legal).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_op_decode
    import acc_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output logic           is_mem,
    output logic           is_branch,
    output logic           is_legal
);

    logic [3:0] w_op;
    logic       w_hi_zero;

    assign w_op = op[3:0];

    // Any set bit above the architected opcode field makes the opcode unknown.
    generate
        if (OPW > 4) begin : g_wide
            assign w_hi_zero = (op[OPW-1:4] == '0);
        end else begin : g_narrow
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        is_mem    = 1'b0;
        is_branch = 1'b0;
        is_legal  = 1'b0;
        if (w_hi_zero) begin
            case (w_op)
                c_op_lda, c_op_sta, c_op_add, c_op_sub, c_op_and, c_op_or: begin
                    is_mem   = 1'b1;
                    is_legal = 1'b1;
                end
                c_op_jmp, c_op_jz, c_op_jc: begin
                    is_branch = 1'b1;
                    is_legal  = 1'b1;
                end
                c_op_nop, c_op_not, c_op_cla, c_op_hlt: begin
                    is_legal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/acc_ctrl_seq.sv
// ============================================================================
// Module   : acc_ctrl_seq
// Purpose  : Fetch/decode/execute sequencer driving the datapath register
//            strobes, memory controls and ALU operation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_ctrl_seq
    import acc_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [OPW-1:0]  ir_op,
    input  logic            acc_zero,
    input  logic            carry,
    output logic            pc_set,
    output logic            ir_set,
    output logic            acc_set,
    output logic            flag_set,
    output logic            pc_clr_n,
    output logic            ir_clr_n,
    output logic            acc_clr_n,
    output logic            pc_sel,
    output logic            addr_sel,
    output logic            mem_we,
    output logic [2:0]      alu_op,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] instr_cnt
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW-1:0] r_instr_cnt;
    logic            r_illegal;

    logic [3:0]      w_op;
    logic            w_is_mem;
    logic            w_is_branch;
    logic            w_is_legal;
    logic            w_take;
    logic            w_retire;
    logic            w_set_illegal;

    assign w_op = ir_op[3:0];

    acc_op_decode #(
        .OPW (OPW)
    ) u_op_decode (
        .op        (ir_op),
        .is_mem    (w_is_mem),
        .is_branch (w_is_branch),
        .is_legal  (w_is_legal)
    );

    always_comb begin
        w_take = 1'b0;
        case (w_op)
            c_op_jmp: w_take = 1'b1;
            c_op_jz:  w_take = acc_zero;
            c_op_jc:  w_take = carry;
            default:  w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_init:   w_state_nxt = c_st_fetch;
            c_st_fetch:  w_state_nxt = c_st_decode;
            c_st_decode: begin
                if (w_is_mem) begin
                    w_state_nxt = c_st_exec;
                end else if (w_is_legal && (w_op == c_op_hlt)) begin
                    w_state_nxt = c_st_halt;
                end else begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_exec:   w_state_nxt = c_st_fetch;
            c_st_halt:   w_state_nxt = run ? c_st_fetch : c_st_halt;
            default:     w_state_nxt = c_st_init;
        endcase
    end

    // An instruction retires on the edge that leaves its last state.
    assign w_retire      = ((r_state == c_st_decode) && !w_is_mem) || (r_state == c_st_exec);
    assign w_set_illegal = (r_state == c_st_decode) && !w_is_legal;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= c_st_init;
            r_instr_cnt <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNTW'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_set    = 1'b0;
        ir_set    = 1'b0;
        acc_set   = 1'b0;
        flag_set  = 1'b0;
        pc_clr_n  = 1'b1;
        ir_clr_n  = 1'b1;
        acc_clr_n = 1'b1;
        pc_sel    = c_pc_sel_inc;
        addr_sel  = c_addr_sel_pc;
        mem_we    = 1'b0;
        alu_op    = c_alu_pass;
        case (r_state)
            c_st_init: begin
                pc_clr_n  = 1'b0;
                ir_clr_n  = 1'b0;
                acc_clr_n = 1'b0;
            end
            c_st_fetch: begin
                ir_set = 1'b1;
                pc_set = 1'b1;
            end
            c_st_decode: begin
                if (w_is_legal) begin
                    if (w_is_branch) begin
                        pc_set = w_take;
                        pc_sel = w_take ? c_pc_sel_opnd : c_pc_sel_inc;
                    end
                    case (w_op)
                        c_op_not: begin
                            acc_set = 1'b1;
                            alu_op  = c_alu_not;
                        end
                        c_op_cla: acc_clr_n = 1'b0;
                        default: ;
                    endcase
                end
            end
            c_st_exec: begin
                addr_sel = c_addr_sel_opnd;
                alu_op   = alu_code(w_op);
                case (w_op)
                    c_op_lda: acc_set = 1'b1;
                    c_op_sta: mem_we  = 1'b1;
                    c_op_add, c_op_sub: begin
                        acc_set  = 1'b1;
                        flag_set = 1'b1;
                    end
                    c_op_and, c_op_or: acc_set = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign halted    = (r_state == c_st_halt);
    assign illegal   = r_illegal;
    assign instr_cnt = r_instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_acc_ctrl_seq.sv
// ============================================================================
// Module   : tb_acc_ctrl_seq
// Purpose  : Scoreboard bench for acc_ctrl_seq with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_ctrl_seq;

    localparam int OPW  = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            clr;
    logic            run;
    logic [OPW-1:0]  ir_op;
    logic            acc_zero;
    logic            carry;
    logic            pc_set, ir_set, acc_set, flag_set;
    logic            pc_clr_n, ir_clr_n, acc_clr_n;
    logic            pc_sel, addr_sel, mem_we;
    logic [2:0]      alu_op;
    logic            halted, illegal;
    logic [CNTW-1:0] instr_cnt;

    acc_ctrl_seq #(.OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .clr(clr), .run(run), .ir_op(ir_op),
        .acc_zero(acc_zero), .carry(carry),
        .pc_set(pc_set), .ir_set(ir_set), .acc_set(acc_set), .flag_set(flag_set),
        .pc_clr_n(pc_clr_n), .ir_clr_n(ir_clr_n), .acc_clr_n(acc_clr_n),
        .pc_sel(pc_sel), .addr_sel(addr_sel), .mem_we(mem_we), .alu_op(alu_op),
        .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_set, ir_set, acc_set, flag_set;
        logic pc_clr_n, ir_clr_n, acc_clr_n;
        logic pc_sel, addr_sel, mem_we;
        logic [2:0] alu_op;
        logic halted, illegal;
        logic [CNTW-1:0] cnt;
    } vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_cnt   = 0;
    bit    m_ill   = 1'b0;
    logic [3:0] cur_ir = 4'h0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t idle_vec();
        vec_t v = '0;
        v.pc_clr_n  = 1'b1;
        v.ir_clr_n  = 1'b1;
        v.acc_clr_n = 1'b1;
        v.illegal   = m_ill;
        v.cnt       = CNTW'(m_cnt);
        return v;
    endfunction

    function automatic vec_t reset_vec();
        return '0;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic step(input vec_t e, input string tag, input logic [3:0] op,
                        input bit az, input bit cy, input bit rn);
        @(posedge clk);
        #1;
        ir_op    = op;
        acc_zero = az;
        carry    = cy;
        run      = rn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic hold_and_release();
        @(posedge clk);
        #1;
        exp_q.push_back(reset_vec());
        tag_q.push_back("reset hold");
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_q.push_back(reset_vec());
        tag_q.push_back("reset release");
    endtask

    task automatic abort_mid(input string tag);
        @(posedge clk);
        #1;
        run = 1'b0;
        #2;
        clr   = 1'b1;
        m_cnt = 0;
        m_ill = 1'b0;
        exp_q.push_back(reset_vec());
        tag_q.push_back(tag);
        hold_and_release();
    endtask

    // Instruction-level model: expands one instruction into its per-cycle outputs.
    // flag < 0 randomises acc_zero/carry; halt_len < 0 randomises the run pulse.
    task automatic exec_instr(input logic [3:0] op, input int flag,
                              input int halt_len, input bit abort_exec);
        vec_t v;
        bit   az, cy, is_mem;
        v = idle_vec();
        v.ir_set = 1'b1;
        v.pc_set = 1'b1;
        step(v, $sformatf("fetch before op %h", op), cur_ir, rb(), rb(), rb());

        cur_ir = op;
        az = (flag < 0) ? rb() : flag[0];
        cy = (flag < 0) ? rb() : flag[0];
        v  = idle_vec();
        case (op)
            4'h7: begin v.acc_set = 1'b1; v.alu_op = 3'd5; end
            4'h8: begin v.pc_set = 1'b1; v.pc_sel = 1'b1; end
            4'h9: begin v.pc_set = az; v.pc_sel = az; end
            4'hA: begin v.pc_set = cy; v.pc_sel = cy; end
            4'hB: v.acc_clr_n = 1'b0;
            default: ;
        endcase
        step(v, $sformatf("decode op %h az %0d cy %0d", op, az, cy), op, az, cy, rb());

        is_mem = (op >= 4'h1) && (op <= 4'h6);
        if (op inside {4'hC, 4'hD, 4'hE}) m_ill = 1'b1;
        if (!is_mem) m_cnt = (m_cnt + 1) % (1 << CNTW);

        if (is_mem && abort_exec) begin
            abort_mid($sformatf("reset during exec op %h", op));
        end else if (is_mem) begin
            v = idle_vec();
            v.addr_sel = 1'b1;
            case (op)
                4'h1: v.acc_set = 1'b1;
                4'h2: v.mem_we  = 1'b1;
                4'h3: begin v.acc_set = 1'b1; v.flag_set = 1'b1; v.alu_op = 3'd1; end
                4'h4: begin v.acc_set = 1'b1; v.flag_set = 1'b1; v.alu_op = 3'd2; end
                4'h5: begin v.acc_set = 1'b1; v.alu_op = 3'd3; end
                default: begin v.acc_set = 1'b1; v.alu_op = 3'd4; end
            endcase
            step(v, $sformatf("exec op %h", op), op, rb(), rb(), rb());
            m_cnt = (m_cnt + 1) % (1 << CNTW);
        end else if (op == 4'hF) begin
            for (int k = 0; k < 16; k++) begin
                bit rn;
                if (halt_len >= 0) rn = (k == halt_len);
                else               rn = (k >= 8) ? 1'b1 : ($urandom_range(0, 2) == 0);
                v = idle_vec();
                v.halted = 1'b1;
                step(v, $sformatf("halt cycle %0d", k), op, rb(), rb(), rn);
                if (rn) break;
            end
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared at the falling edge.
    initial begin
        vec_t  e;
        vec_t  act;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                act.pc_set = pc_set;     act.ir_set = ir_set;
                act.acc_set = acc_set;   act.flag_set = flag_set;
                act.pc_clr_n = pc_clr_n; act.ir_clr_n = ir_clr_n;
                act.acc_clr_n = acc_clr_n;
                act.pc_sel = pc_sel;     act.addr_sel = addr_sel;
                act.mem_we = mem_we;     act.alu_op = alu_op;
                act.halted = halted;     act.illegal = illegal;
                act.cnt = instr_cnt;
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", t, act, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1; run = 1'b0; ir_op = '0; acc_zero = 1'b0; carry = 1'b0;
        hold_and_release();

        exec_instr(4'h1, -1, 0, 1'b0);
        exec_instr(4'h3, -1, 0, 1'b0);
        exec_instr(4'h2, -1, 0, 1'b0);
        abort_mid("reset during fetch");

        exec_instr(4'h9, 1, 0, 1'b0);
        exec_instr(4'h9, 0, 0, 1'b0);
        exec_instr(4'hA, 1, 0, 1'b0);
        exec_instr(4'hA, 0, 0, 1'b0);
        exec_instr(4'h8, -1, 0, 1'b0);
        exec_instr(4'hB, -1, 0, 1'b0);
        exec_instr(4'h7, -1, 0, 1'b0);

        exec_instr(4'hD, -1, 0, 1'b0);
        for (int i = 0; i < 3; i++) exec_instr(4'h0, -1, 0, 1'b0);

        exec_instr(4'hF, -1, 5, 1'b0);
        exec_instr(4'hF, -1, 0, 1'b0);
        exec_instr(4'h2, -1, 0, 1'b1);

        for (int i = 0; i < 256; i++) exec_instr(4'h0, -1, 0, 1'b0);
        exec_instr(4'h1, -1, 0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            exec_instr(4'($urandom_range(0, 15)), -1, -1, 1'b0);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
